// File: rtl/br_pred_ctrl_pkg.sv
// Shared widths, default counter value and FSM encoding for the branch predictor controller.
package br_pred_ctrl_pkg;

  localparam int unsigned AddrWidth      = 32;
  localparam int unsigned InstWidth      = 32;
  localparam int unsigned ByteBitWidth   = 8;
  localparam int unsigned PredCntWidth   = 2;
  localparam int unsigned PredTableDepth = 1024;
  localparam int unsigned PredMaxDepth   = 8;

  // Weakly-taken reset value of a counter at the default counter width.
  localparam logic [PredCntWidth-1:0] CNT_DEF = PredCntWidth'(1) << (PredCntWidth - 1);

  typedef enum logic {
    PRED_INIT,
    PRED_RUN
  } pred_state_e;

endpackage

// File: rtl/br_pred_hist.sv
// Circular FIFO of in-flight predictions {index, counter}; flush empties it in one cycle.
module br_pred_hist #(
  parameter int unsigned W     = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic [$clog2(DEPTH):0]     occ
);

  localparam int unsigned PTR   = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR + 1;

  logic [W-1:0]   mem [DEPTH];
  logic [PTR-1:0] rd_ptr;
  logic [PTR-1:0] wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_pop   = pop & (occ != '0);
  assign do_push  = push & ((occ != OCC_W'(DEPTH)) | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || !flush_) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/br_pred_ctrl.sv
// Saturating-counter table controller: post-reset sweep, lookup/commit arbitration
// on a single-port RAM, and history tracking of in-flight predictions.
module br_pred_ctrl
  import br_pred_ctrl_pkg::*;
#(
  parameter int unsigned ADDR     = AddrWidth,
  parameter int unsigned CNT      = PredCntWidth,
  parameter int unsigned DEPTH    = PredTableDepth,
  parameter int unsigned HIST     = PredMaxDepth,
  parameter int unsigned ADDR_OFS = $clog2(InstWidth / ByteBitWidth)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_,
  input  logic                     br_,
  input  logic [ADDR-1:0]          br_pc,
  output logic                     br_stall,
  output logic                     br_pred_v_,
  output logic                     br_pred,
  input  logic                     br_commit_,
  input  logic                     br_result,
  output logic                     tbl_en_,
  output logic                     tbl_we_,
  output logic [$clog2(DEPTH)-1:0] tbl_addr,
  output logic [CNT-1:0]           tbl_wd,
  input  logic [CNT-1:0]           tbl_rd,
  output logic                     hist_err
);

  localparam int unsigned PTR   = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(HIST) + 1;
  localparam int unsigned ENT_W = PTR + CNT;
  localparam logic [CNT-1:0] CntDef = CNT'(1) << (CNT - 1);

  pred_state_e      state;
  logic [PTR-1:0]   sweep_idx;
  logic             pend;
  logic [PTR-1:0]   pend_idx;

  logic [PTR-1:0]   lkp_idx;
  logic [OCC_W-1:0] occ;
  logic [ENT_W-1:0] head;
  logic [PTR-1:0]   head_idx;
  logic [CNT-1:0]   head_cnt;
  logic [CNT-1:0]   upd_cnt;
  logic             in_run;
  logic             commit;
  logic             hist_empty;
  logic             do_upd;
  logic             accept;
  logic             push;
  logic             unused_pc;

  assign lkp_idx    = br_pc[PTR+ADDR_OFS-1:ADDR_OFS];
  assign unused_pc  = ^{br_pc[ADDR-1:PTR+ADDR_OFS], br_pc[ADDR_OFS-1:0]};
  assign in_run     = (state == PRED_RUN);
  assign commit     = !br_commit_;
  assign hist_empty = (occ == '0);
  assign do_upd     = !reset & in_run & commit & !hist_empty;
  assign head_idx   = head[ENT_W-1:CNT];
  assign head_cnt   = head[CNT-1:0];

  assign br_stall = reset | !in_run | commit | !flush_ |
                    ((occ + OCC_W'(pend)) == OCC_W'(HIST));
  assign accept   = !br_ & !br_stall;
  assign push     = pend & flush_;

  // Prediction comes straight off the RAM read data to hold 1-cycle lookup latency.
  assign br_pred_v_ = !push;
  assign br_pred    = push & tbl_rd[CNT-1];

  always_comb begin
    upd_cnt = head_cnt;
    if (br_result) begin
      if (head_cnt != '1) upd_cnt = head_cnt + CNT'(1);
    end else begin
      if (head_cnt != '0) upd_cnt = head_cnt - CNT'(1);
    end
  end

  // RAM port priority: sweep, then commit write, then lookup read.
  always_comb begin
    tbl_en_  = 1'b1;
    tbl_we_  = 1'b1;
    tbl_addr = '0;
    tbl_wd   = '0;
    if (!reset) begin
      if (state == PRED_INIT) begin
        tbl_en_  = 1'b0;
        tbl_we_  = 1'b0;
        tbl_addr = sweep_idx;
        tbl_wd   = CntDef;
      end else if (do_upd) begin
        tbl_en_  = 1'b0;
        tbl_we_  = 1'b0;
        tbl_addr = head_idx;
        tbl_wd   = upd_cnt;
      end else if (accept) begin
        tbl_en_  = 1'b0;
        tbl_addr = lkp_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PRED_INIT;
      sweep_idx <= '0;
      pend      <= 1'b0;
      pend_idx  <= '0;
      hist_err  <= 1'b0;
    end else begin
      case (state)
        PRED_INIT: begin
          sweep_idx <= sweep_idx + PTR'(1);
          if (sweep_idx == PTR'(DEPTH - 1)) state <= PRED_RUN;
        end
        PRED_RUN: state <= PRED_RUN;
        default:  state <= PRED_INIT;
      endcase
      pend <= accept;
      if (accept) pend_idx <= lkp_idx;
      if (commit && (!in_run || hist_empty)) hist_err <= 1'b1;
    end
  end

  br_pred_hist #(
    .W     (ENT_W),
    .DEPTH (HIST)
  ) u_hist (
    .clk       (clk),
    .reset     (reset),
    .flush_    (flush_),
    .push      (push),
    .push_data ({pend_idx, tbl_rd}),
    .pop       (do_upd),
    .pop_data  (head),
    .occ       (occ)
  );

endmodule

// File: tb/tb_br_pred_ctrl.sv
// Directed + random bench for br_pred_ctrl against a queue-based reference model and a RAM model.
module tb_br_pred_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned HIST  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush_ = 1'b1;
  logic        br_ = 1'b1;
  logic [31:0] br_pc = '0;
  logic        br_stall;
  logic        br_pred_v_;
  logic        br_pred;
  logic        br_commit_ = 1'b1;
  logic        br_result = 1'b0;
  logic        tbl_en_;
  logic        tbl_we_;
  logic [3:0]  tbl_addr;
  logic [1:0]  tbl_wd;
  logic [1:0]  tbl_rd;
  logic        hist_err;

  br_pred_ctrl #(
    .ADDR(32), .CNT(2), .DEPTH(DEPTH), .HIST(HIST), .ADDR_OFS(2)
  ) dut (
    .clk(clk), .reset(reset), .flush_(flush_), .br_(br_), .br_pc(br_pc),
    .br_stall(br_stall), .br_pred_v_(br_pred_v_), .br_pred(br_pred),
    .br_commit_(br_commit_), .br_result(br_result),
    .tbl_en_(tbl_en_), .tbl_we_(tbl_we_), .tbl_addr(tbl_addr),
    .tbl_wd(tbl_wd), .tbl_rd(tbl_rd), .hist_err(hist_err)
  );

  always #5 clk = ~clk;

  // Single-port counter RAM, 1-cycle read latency.
  logic [1:0] ram [DEPTH];
  logic [1:0] rd_q = '0;
  assign tbl_rd = rd_q;
  always @(posedge clk) begin
    if (!tbl_en_) begin
      if (!tbl_we_) ram[tbl_addr] <= tbl_wd;
      else          rd_q <= ram[tbl_addr];
    end
  end

  typedef struct { int idx; int cnt; } ent_t;
  ent_t q[$];
  int   init_left;
  bit   pend;
  int   pend_idx;
  int   pend_cnt;
  bit   err;
  int   tbl [DEPTH];
  int   checks = 0;
  int   errors = 0;

  function automatic int sat(int c, bit taken);
    if (taken) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1; br_ = 1'b1; br_commit_ = 1'b1; flush_ = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_tbl_en_", tbl_en_, 1'b1);
    chk("rst_stall", br_stall, 1'b1);
    chk("rst_pred_v_", br_pred_v_, 1'b1);
    chk("rst_pred", br_pred, 1'b0);
    chk("rst_hist_err", hist_err, 1'b0);
    init_left = DEPTH;
    q.delete();
    pend = 1'b0;
    err  = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input bit b_n, input logic [31:0] pc, input bit c_n, input bit res, input bit f_n);
    bit in_init, stall, acc, e_en, e_we, valid;
    int e_addr, e_wd, idx;
    @(negedge clk);
    reset = 1'b0; br_ = b_n; br_pc = pc; br_commit_ = c_n; br_result = res; flush_ = f_n;
    #1;
    idx     = int'((pc >> 2) & 32'hF);
    in_init = (init_left > 0);
    stall   = in_init || !c_n || !f_n || ((q.size() + int'(pend)) == HIST);
    acc     = !b_n && !stall;
    valid   = pend && f_n;
    e_en = 1'b0; e_we = 1'b0; e_addr = 0; e_wd = 0;
    if (in_init) begin
      e_en = 1'b1; e_we = 1'b1; e_addr = DEPTH - init_left; e_wd = 2;
    end else if (!c_n && q.size() > 0) begin
      e_en = 1'b1; e_we = 1'b1; e_addr = q[0].idx; e_wd = sat(q[0].cnt, res);
    end else if (acc) begin
      e_en = 1'b1; e_addr = idx;
    end
    chk("stall", br_stall, stall);
    chk("tbl_en_", tbl_en_, !e_en);
    if (e_en) begin
      chk("tbl_we_", tbl_we_, !e_we);
      chk("tbl_addr", tbl_addr, e_addr);
      if (e_we) chk("tbl_wd", tbl_wd, e_wd);
    end
    chk("pred_v_", br_pred_v_, !valid);
    if (valid) chk("pred", br_pred, (pend_cnt >> 1) & 1);
    chk("hist_err", hist_err, err);
    @(posedge clk);
    if (!c_n) begin
      if (in_init || q.size() == 0) err = 1'b1;
      else begin
        tbl[q[0].idx] = sat(q[0].cnt, res);
        void'(q.pop_front());
      end
    end
    if (valid) q.push_back('{pend_idx, pend_cnt});
    if (!f_n) q.delete();
    pend = acc;
    if (acc) begin
      pend_idx = idx;
      pend_cnt = tbl[idx];
    end
    if (in_init) begin
      tbl[DEPTH - init_left] = 2;
      init_left--;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(1'b0, pc, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic commit(input bit res);
    step(1'b1, 32'h0, 1'b0, res, 1'b1);
  endtask

  task automatic check_ram(input string tag, input int idx, input int exp);
    #2;
    chk(tag, ram[idx], exp);
  endtask

  initial begin
    do_reset(2);
    idle(DEPTH);
    #2;
    for (int i = 0; i < DEPTH; i++) chk("sweep_ram", ram[i], 2);

    // pc 0x40 -> index 0, weakly taken, then not-taken commit
    lookup(32'h40); idle(1); commit(1'b0); idle(1);
    check_ram("pc40_ram", 0, 1);

    // saturate high on index 1
    for (int r = 0; r < 2; r++) begin lookup(32'h44); idle(1); commit(1'b1); end
    idle(1); check_ram("sat_hi_ram", 1, 3);

    // saturate low on index 2
    for (int r = 0; r < 3; r++) begin lookup(32'h48); idle(1); commit(1'b0); end
    idle(1); check_ram("sat_lo_ram", 2, 0);

    // commit and lookup in the same cycle: commit wins, lookup retried
    lookup(32'h4C); idle(1);
    step(1'b0, 32'h50, 1'b0, 1'b1, 1'b1);
    lookup(32'h50); idle(1);
    commit(1'b1); idle(1);

    // fill the history: ninth request stalls, a commit frees a slot
    for (int i = 0; i < HIST; i++) lookup($urandom);
    lookup(32'h60);
    step(1'b0, 32'h60, 1'b0, 1'b1, 1'b1);
    lookup(32'h60); idle(1);
    for (int i = 0; i < HIST; i++) commit(1'($urandom));
    idle(1);

    // flush with one pending lookup and three queued entries
    do_reset(1);
    idle(DEPTH);
    for (int i = 0; i < 4; i++) lookup(32'h100 + 32'(i * 4));
    step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    commit(1'b1);
    idle(2);

    // reset mid-sweep restarts from index 0
    do_reset(1);
    idle(5);
    do_reset(2);
    idle(DEPTH);
    #2;
    for (int i = 0; i < DEPTH; i++) chk("resweep_ram", ram[i], 2);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      step(1'($urandom_range(9) >= 6), $urandom,
           1'($urandom_range(9) >= 3), 1'($urandom),
           1'($urandom_range(99) >= 3));
    end
    idle(2);
    #2;
    for (int i = 0; i < DEPTH; i++) chk("final_ram", ram[i], tbl[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
